spi_master: RTL

- Mode-0 (CPOL=0, CPHA=0) SPI master. Counterpart to the team's SPI slave core.
- Serialises one WIDTH-bit word MSB-first on MOSI and captures WIDTH bits from MISO in the same transaction.
- Generates SCLK from clk with a programmable half-period and controls CS_n.
- Presents a start/busy/done handshake to local logic.

---
 rtl/spi_master.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/spi_master.sv
// Mode-0 SPI master: shifts one WIDTH-bit word out on MOSI (MSB first) while capturing MISO.
// Optional SPI_MASTER_BURST_EN keeps CS_n asserted across back-to-back words.
module spi_master #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned CLK_DIV = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dataIn,
`ifdef SPI_MASTER_BURST_EN
  input  logic             hold,
  input  logic             csRelease,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] dataOut,
  output logic             CS_n,
  output logic             SCLK,
  output logic             MOSI,
  input  logic             MISO
);

  localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned CntW = $clog2(WIDTH + 1);
  localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);
  localparam logic [CntW-1:0] BitsAll = CntW'(WIDTH);

  // The slave's clk-domain edge detector needs at least two clk cycles per SCLK level.
  if (CLK_DIV < 2) begin : gen_bad_clk_div
    $error("spi_master: CLK_DIV must be >= 2");
  end
  if (WIDTH < 2) begin : gen_bad_width
    $error("spi_master: WIDTH must be >= 2");
  end

`ifdef SPI_MASTER_BURST_EN
  typedef enum logic [2:0] {StIdle, StLead, StHigh, StLow, StFinish, StBurst} state_e;
`else
  typedef enum logic [2:0] {StIdle, StLead, StHigh, StLow, StFinish} state_e;
`endif

  state_e            state_q, state_d;
  logic [DivW-1:0]   div_q, div_d;
  logic [CntW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0]  tx_q, tx_d;
  logic [WIDTH-1:0]  rx_q, rx_d;
  logic [WIDTH-1:0]  dout_q, dout_d;
  logic              cs_n_q, cs_n_d;
  logic              sclk_q, sclk_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
`ifdef SPI_MASTER_BURST_EN
  logic              hold_q, hold_d;
`endif

  logic div_last;
  logic bits_left;
  logic accept;

  assign div_last  = (div_q == DivLast);
  assign bits_left = (bit_cnt_q != BitsAll);
`ifdef SPI_MASTER_BURST_EN
  assign accept = start && ((state_q == StIdle) || (state_q == StBurst));
`else
  assign accept = start && (state_q == StIdle);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      div_q     <= '0;
      bit_cnt_q <= '0;
      tx_q      <= '0;
      rx_q      <= '0;
      dout_q    <= '0;
      cs_n_q    <= 1'b1;
      sclk_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef SPI_MASTER_BURST_EN
      hold_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      bit_cnt_q <= bit_cnt_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      dout_q    <= dout_d;
      cs_n_q    <= cs_n_d;
      sclk_q    <= sclk_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
`ifdef SPI_MASTER_BURST_EN
      hold_q    <= hold_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:   if (start) state_d = StLead;
      StLead:   if (div_last) state_d = StHigh;
      StHigh:   if (div_last) state_d = StLow;
      StLow: begin
        if (div_last) begin
          if (bits_left) begin
            state_d = StHigh;
          end else begin
`ifdef SPI_MASTER_BURST_EN
            state_d = hold_q ? StBurst : StFinish;
`else
            state_d = StFinish;
`endif
          end
        end
      end
      StFinish: state_d = StIdle;
`ifdef SPI_MASTER_BURST_EN
      StBurst: begin
        if (start)          state_d = StLead;
        else if (csRelease) state_d = StFinish;
      end
`endif
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    div_d     = div_q;
    bit_cnt_d = bit_cnt_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    dout_d    = dout_q;
    cs_n_d    = cs_n_q;
    sclk_d    = sclk_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
`ifdef SPI_MASTER_BURST_EN
    hold_d    = hold_q;
`endif
    if (accept) begin
      tx_d      = dataIn;
      cs_n_d    = 1'b0;
      busy_d    = 1'b1;
      div_d     = '0;
      bit_cnt_d = '0;
`ifdef SPI_MASTER_BURST_EN
      hold_d    = hold;
`endif
    end else begin
      if ((state_q == StLead) || (state_q == StHigh) || (state_q == StLow)) begin
        div_d = div_last ? '0 : div_q + 1'b1;
      end
      // Rising SCLK edge: sample MISO on the edge that raises SCLK.
      if (div_last && ((state_q == StLead) || ((state_q == StLow) && bits_left))) begin
        sclk_d    = 1'b1;
        rx_d      = {rx_q[WIDTH-2:0], MISO};
        bit_cnt_d = bit_cnt_q + 1'b1;
      end
      if (div_last && (state_q == StHigh)) begin
        sclk_d = 1'b0;
        if (bits_left) tx_d = tx_q << 1;
      end
      if (div_last && (state_q == StLow) && !bits_left) begin
        busy_d = 1'b0;
        done_d = 1'b1;
        dout_d = rx_q;
`ifdef SPI_MASTER_BURST_EN
        cs_n_d = !hold_q;
`else
        cs_n_d = 1'b1;
`endif
      end
`ifdef SPI_MASTER_BURST_EN
      if ((state_q == StBurst) && csRelease) cs_n_d = 1'b1;
`endif
    end
  end

  // MOSI is the top of the shift register, so it holds the last bit once shifting stops.
  always_comb begin
    busy    = busy_q;
    done    = done_q;
    dataOut = dout_q;
    CS_n    = cs_n_q;
    SCLK    = sclk_q;
    MOSI    = tx_q[WIDTH-1];
  end

endmodule
